mem_bus_interface: RTL and testbench
====================================

Name: mem_bus_interface

Overview:
- Bus-sink counterpart to the CPU's tri-source bus driver: it consumes the shared 16-bit BUS into MAR and MDR.
- It runs the SRAM read/write cycles the datapath requests, with a fixed wait-state sequencer.
- It sits between the datapath and the off-chip SRAM pins, and returns a one-cycle Done pulse to the control FSM.

Parameters:
- WAIT_STATES, 1, number of extra SRAM wait cycles per access. Legal range 0..15.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- BUS  in  16  shared datapath bus
- LD_MAR  in  1  load MAR from BUS
- LD_MDR  in  1  load MDR; source chosen by MIO_EN
- MIO_EN  in  1  MDR source select: 1 = Data_from_SRAM, 0 = BUS
- MemRd  in  1  request a read at MAR (sampled in IDLE only)
- MemWr  in  1  request a write of MDR to MAR (sampled in IDLE only)
- Data_from_SRAM  in  16  SRAM read data
- MAR  out  16  memory address register
- MDR  out  16  memory data register
- ADDR  out  16  SRAM address; always equals MAR
- Data_to_SRAM  out  16  SRAM write data; always equals MDR
- Mem_CE_N  out  1  chip enable, active-low
- Mem_OE_N  out  1  output enable, active-low
- Mem_WE_N  out  1  write enable, active-low
- Busy  out  1  high while in READ or WRITE
- Done  out  1  one-cycle completion pulse

Behaviour:
- Reset (sync, active-high):
  - MAR = 0, MDR = 0, state = IDLE, cnt = 0.
  - Mem_CE_N = Mem_OE_N = Mem_WE_N = 1; Busy = 0; Done = 0.
  - Reset in any state, including mid-access, aborts immediately. No Done is issued and strobes deassert on the next edge.
- States: IDLE, READ, WRITE, DONE. cnt is a 5-bit counter, cleared on entry to READ or WRITE.
- IDLE:
  - All strobes high.
  - LD_MAR: MAR <= BUS.
  - LD_MDR: MDR <= (MIO_EN ? Data_from_SRAM : BUS).
  - MemRd -> READ. MemWr (with MemRd low) -> WRITE.
  - MemRd and MemWr together: read wins, write dropped.
  - LD_MAR in the same cycle as MemRd/MemWr: MAR updates at that edge, so the access uses the new MAR.
- READ:
  - Mem_CE_N = 0, Mem_OE_N = 0, Mem_WE_N = 1.
  - cnt increments each cycle.
  - When cnt == WAIT_STATES: MDR <= Data_from_SRAM at that edge, then -> DONE.
  - READ lasts WAIT_STATES+1 cycles.
- WRITE:
  - Mem_CE_N = 0, Mem_OE_N = 1.
  - Mem_WE_N = 0 while cnt <= WAIT_STATES, then 1 for a single hold cycle (cnt == WAIT_STATES+1), giving address/data hold after WE rises.
  - Then -> DONE. WRITE lasts WAIT_STATES+2 cycles.
- DONE:
  - Done = 1, strobes high, -> IDLE next cycle.
  - LD_MAR/LD_MDR are honoured as in IDLE. MemRd/MemWr are ignored.
- While Busy:
  - LD_MAR, LD_MDR, MemRd and MemWr are all ignored.
  - MAR and MDR hold stable, except the READ terminal capture into MDR.
- Latency (request sampled at edge ending cycle T):
  - Read: Done and new MDR visible in cycle T+WAIT_STATES+2.
  - Write: Done in cycle T+WAIT_STATES+3.
- Outputs ADDR, Data_to_SRAM and Busy are combinational from registers/state. No bus-to-SRAM combinational path exists.

Optional Feature:
- Macro SRAM_READY_EN.
- Defined:
  - Adds input port Mem_Ready (1 bit), placed after Data_from_SRAM.
  - READ terminal condition becomes cnt >= WAIT_STATES && Mem_Ready.
  - WRITE leaves the WE-low phase only when cnt >= WAIT_STATES && Mem_Ready; the hold cycle follows.
  - cnt saturates at 31 while waiting. There is no timeout.
- Undefined:
  - Port absent; fixed timing exactly as above.

Test Plan:
- Reset then idle -> MAR = 0, MDR = 0, all strobes 1, Busy = 0, Done = 0 for 5 cycles.
- BUS = 0x3000 with LD_MAR; BUS = 0xBEEF with LD_MDR, MIO_EN = 0 -> MAR = 0x3000, MDR = 0xBEEF next cycle; ADDR = 0x3000, Data_to_SRAM = 0xBEEF.
- Read, WAIT_STATES = 1, MAR = 0x0042, Data_from_SRAM = 0x1234, MemRd pulsed in cycle T:
  - CE/OE low in T+1..T+2.
  - MDR = 0x1234 and Done = 1 in T+3.
  - Busy high only in T+1..T+2.
- Write, WAIT_STATES = 1, MDR = 0xA5A5, MemWr in T:
  - WE low in T+1..T+2, high with CE low in T+3.
  - Done in T+4.
  - Data_to_SRAM = 0xA5A5 throughout.
- MemRd and MemWr together -> read sequence only (WE never low). A second MemRd and an LD_MAR with BUS = 0xFFFF, both during Busy, are ignored; MAR is unchanged.
- Reset asserted in the 2nd WRITE cycle -> next cycle all strobes 1, state IDLE, MAR = MDR = 0, no Done pulse ever.

Source files
------------

// File: rtl/mem_bus_interface.sv
// rtl/mem_bus_interface.sv - MAR/MDR bus sink with fixed wait-state SRAM access sequencer.
// Optional SRAM_READY_EN adds a Mem_Ready handshake that stretches the terminal wait cycle.
module mem_bus_interface #(
  parameter int WAIT_STATES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] BUS,
  input  logic        LD_MAR,
  input  logic        LD_MDR,
  input  logic        MIO_EN,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [15:0] Data_from_SRAM,
`ifdef SRAM_READY_EN
  input  logic        Mem_Ready,
`endif
  output logic [15:0] MAR,
  output logic [15:0] MDR,
  output logic [15:0] ADDR,
  output logic [15:0] Data_to_SRAM,
  output logic        Mem_CE_N,
  output logic        Mem_OE_N,
  output logic        Mem_WE_N,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_t;

  localparam logic [4:0] WAIT_CNT = 5'(WAIT_STATES);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] mdr_q, mdr_d;
  logic        hold_q, hold_d;

  logic [4:0]  cnt_inc;
  logic        wait_last;

`ifdef SRAM_READY_EN
  // Counter saturates so an indefinitely stalled SRAM cannot wrap it back below WAIT_CNT.
  assign cnt_inc   = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
  assign wait_last = (cnt_q >= WAIT_CNT) && Mem_Ready;
`else
  assign cnt_inc   = cnt_q + 5'd1;
  assign wait_last = (cnt_q == WAIT_CNT);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    hold_d  = hold_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (LD_MAR) begin
          mar_d = BUS;
        end
        if (LD_MDR) begin
          mdr_d = MIO_EN ? Data_from_SRAM : BUS;
        end
        if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end else if (MemRd) begin
          state_d = ST_READ;
          cnt_d   = 5'd0;
        end else if (MemWr) begin
          state_d = ST_WRITE;
          cnt_d   = 5'd0;
          hold_d  = 1'b0;
        end
      end
      ST_READ: begin
        cnt_d = cnt_inc;
        if (wait_last) begin
          mdr_d   = Data_from_SRAM;
          state_d = ST_DONE;
        end
      end
      ST_WRITE: begin
        cnt_d = cnt_inc;
        // hold_q marks the single cycle with WE released but CE/address/data still driven.
        if (hold_q) begin
          state_d = ST_DONE;
        end else if (wait_last) begin
          hold_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      mar_q   <= 16'h0000;
      mdr_q   <= 16'h0000;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      hold_q  <= hold_d;
    end
  end

  assign MAR          = mar_q;
  assign MDR          = mdr_q;
  assign ADDR         = mar_q;
  assign Data_to_SRAM = mdr_q;
  assign Busy         = (state_q == ST_READ) || (state_q == ST_WRITE);
  assign Done         = (state_q == ST_DONE);
  assign Mem_CE_N     = !Busy;
  assign Mem_OE_N     = !(state_q == ST_READ);
  assign Mem_WE_N     = !((state_q == ST_WRITE) && !hold_q);

endmodule

// File: tb/tb_mem_bus_interface.sv
// tb/tb_mem_bus_interface.sv - scoreboard bench for mem_bus_interface with WAIT_STATES = 1.
module tb_mem_bus_interface;

  logic        Clk;
  logic        Reset;
  logic [15:0] BUS;
  logic        LD_MAR;
  logic        LD_MDR;
  logic        MIO_EN;
  logic        MemRd;
  logic        MemWr;
  logic [15:0] Data_from_SRAM;
`ifdef SRAM_READY_EN
  logic        Mem_Ready;
`endif
  logic [15:0] MAR;
  logic [15:0] MDR;
  logic [15:0] ADDR;
  logic [15:0] Data_to_SRAM;
  logic        Mem_CE_N;
  logic        Mem_OE_N;
  logic        Mem_WE_N;
  logic        Busy;
  logic        Done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int we_low_cnt = 0;
  logic [16:0] sb[$];

  mem_bus_interface #(.WAIT_STATES(1)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .BUS            (BUS),
    .LD_MAR         (LD_MAR),
    .LD_MDR         (LD_MDR),
    .MIO_EN         (MIO_EN),
    .MemRd          (MemRd),
    .MemWr          (MemWr),
    .Data_from_SRAM (Data_from_SRAM),
`ifdef SRAM_READY_EN
    .Mem_Ready      (Mem_Ready),
`endif
    .MAR            (MAR),
    .MDR            (MDR),
    .ADDR           (ADDR),
    .Data_to_SRAM   (Data_to_SRAM),
    .Mem_CE_N       (Mem_CE_N),
    .Mem_OE_N       (Mem_OE_N),
    .Mem_WE_N       (Mem_WE_N),
    .Busy           (Busy),
    .Done           (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (Done) begin
        found = 1'b1;
        break;
      end
      next();
    end
    check("done_seen", 32'(found), 32'd1);
  endtask

  // Scoreboard side: every Done pulse must match the oldest outstanding request.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (!Mem_WE_N) we_low_cnt++;
      if (Done) begin
        logic [16:0] e;
        done_cnt++;
        if (sb.size() == 0) begin
          check("sb_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          if (e[16]) check("sb_rd_mdr", 32'(MDR), 32'(e[15:0]));
          else       check("sb_wr_data", 32'(Data_to_SRAM), 32'(e[15:0]));
        end
      end
    end
  end

  initial begin
    logic [2:0] wr_strb[4];
    logic       wr_done[4];
    wr_strb = '{3'b010, 3'b010, 3'b011, 3'b111};
    wr_done = '{1'b0, 1'b0, 1'b0, 1'b1};

    Reset = 1'b1; BUS = '0; LD_MAR = 0; LD_MDR = 0; MIO_EN = 0;
    MemRd = 0; MemWr = 0; Data_from_SRAM = 16'hDEAD;
`ifdef SRAM_READY_EN
    Mem_Ready = 1'b1;
`endif
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      next();
      check("rst_mar", 32'(MAR), 32'h0);
      check("rst_mdr", 32'(MDR), 32'h0);
      check("rst_strb", 32'({Mem_CE_N, Mem_OE_N, Mem_WE_N}), 32'h7);
      check("rst_busy_done", 32'({Busy, Done}), 32'h0);
    end

    BUS = 16'h3000; LD_MAR = 1;
    next();
    LD_MAR = 0; BUS = 16'hBEEF; LD_MDR = 1; MIO_EN = 0;
    next();
    LD_MDR = 0;
    check("ld_mar", 32'(MAR), 32'h3000);
    check("ld_mdr", 32'(MDR), 32'hBEEF);
    check("ld_addr", 32'(ADDR), 32'h3000);
    check("ld_dts", 32'(Data_to_SRAM), 32'hBEEF);

    // Read of 0x0042
    BUS = 16'h0042; LD_MAR = 1;
    next();
    LD_MAR = 0; Data_from_SRAM = 16'h1234; MemRd = 1;
    sb.push_back({1'b1, 16'h1234});
    next();
    MemRd = 0;
    check("rd_t1_strb", 32'({Mem_CE_N, Mem_OE_N, Mem_WE_N}), 32'h1);
    check("rd_t1_busy_done", 32'({Busy, Done}), 32'h2);
    check("rd_addr", 32'(ADDR), 32'h0042);
    next();
    check("rd_t2_strb", 32'({Mem_CE_N, Mem_OE_N, Mem_WE_N}), 32'h1);
    check("rd_t2_busy_done", 32'({Busy, Done}), 32'h2);
    check("rd_t2_mdr_hold", 32'(MDR), 32'hBEEF);
    next();
    check("rd_t3_busy_done", 32'({Busy, Done}), 32'h1);
    check("rd_t3_mdr", 32'(MDR), 32'h1234);
    check("rd_t3_strb", 32'({Mem_CE_N, Mem_OE_N, Mem_WE_N}), 32'h7);
    next();
    check("rd_idle_done", 32'(Done), 32'h0);

    // Write of 0xA5A5
    BUS = 16'hA5A5; LD_MDR = 1; MIO_EN = 0;
    next();
    LD_MDR = 0; MemWr = 1;
    sb.push_back({1'b0, 16'hA5A5});
    next();
    MemWr = 0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wr_t%0d_strb", i + 1), 32'({Mem_CE_N, Mem_OE_N, Mem_WE_N}), 32'(wr_strb[i]));
      check($sformatf("wr_t%0d_done", i + 1), 32'(Done), 32'(wr_done[i]));
      check($sformatf("wr_t%0d_busy", i + 1), 32'(Busy), 32'(!wr_done[i]));
      check($sformatf("wr_t%0d_dts", i + 1), 32'(Data_to_SRAM), 32'hA5A5);
      next();
    end

    // Simultaneous read/write plus requests during Busy
    we_low_cnt = 0;
    Data_from_SRAM = 16'h5678; MemRd = 1; MemWr = 1;
    sb.push_back({1'b1, 16'h5678});
    next();
    MemWr = 0; LD_MAR = 1; BUS = 16'hFFFF;
    check("both_busy", 32'(Busy), 32'h1);
    next();
    MemRd = 0; LD_MAR = 0;
    check("both_mar_hold", 32'(MAR), 32'h0042);
    wait_done(10);
    check("both_mar_final", 32'(MAR), 32'h0042);
    check("both_we_never_low", 32'(we_low_cnt), 32'h0);
    next();
    check("both_idle", 32'({Busy, Done}), 32'h0);

    // Reset during the second WRITE cycle
    MemWr = 1;
    next();
    MemWr = 0;
    next();
    check("abort_we_low", 32'(Mem_WE_N), 32'h0);
    Reset = 1'b1;
    next();
    check("abort_strb", 32'({Mem_CE_N, Mem_OE_N, Mem_WE_N}), 32'h7);
    check("abort_busy_done", 32'({Busy, Done}), 32'h0);
    check("abort_mar", 32'(MAR), 32'h0);
    check("abort_mdr", 32'(MDR), 32'h0);
    Reset = 1'b0;
    repeat (8) next();

    check("done_count", 32'(done_cnt), 32'd3);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
